alu_pipe: RTL and testbench

Parametrised, registered ALU with a valid/ready handshake on both sides and full flag generation. Single-cycle ops: add, subtract, logic, set-less-than, shifts. Multiply runs as an iterative multi-cycle shift-add. The block sits between operand fetch and writeback in the execute path. It stalls upstream while a multiply is in flight or its result is unconsumed.

---
 rtl/alu_pipe.sv | 138 +++++++++++++
 tb/tb_alu_pipe.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Registered execute-stage ALU with valid/ready on both sides and full flag generation.
// Single-cycle ops load the output register directly; MUL runs as a WIDTH-cycle shift-add.
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] aluIn1,
  input  logic [WIDTH-1:0] aluIn2,
  input  logic [3:0]       aluOp,
  input  logic             inValid,
  output logic             inReady,
  output logic [WIDTH-1:0] aluOut,
  output logic             outValid,
  input  logic             outReady,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_err
);
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
                         OP_XOR = 4'd4, OP_SLT = 4'd5, OP_SLTU = 4'd6, OP_SHL = 4'd7,
                         OP_SHR = 4'd8, OP_ASR = 4'd9, OP_MUL = 4'd10;

  typedef enum logic {IDLE, MUL} state_t;
  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic z, n, c, v, err;
  } result_t;

  state_t             state, state_nxt;
  logic [SHW-1:0]     cnt;
  logic [2*WIDTH-1:0] mcand, acc, acc_nxt;
  logic [WIDTH-1:0]   mplier, b_eff;
  logic [WIDTH:0]     sum, shl_w, shr_w, asr_w;
  logic [SHW-1:0]     amt;
  logic               sub, accept, mul_done;
  result_t            alu_r, mul_r, out_r;

  assign inReady  = (state == IDLE) && (!outValid || outReady);
  assign accept   = inValid && inReady;
  assign mul_done = (state == MUL) && (cnt == SHW'(WIDTH-1));

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept && aluOp == OP_MUL) state_nxt = MUL;
      MUL:  if (mul_done)                  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shifts carry one guard bit so the last bit shifted out falls out as c (0 for amount 0).
  always_comb begin
    sub   = (aluOp == OP_SUB);
    b_eff = sub ? ~aluIn2 : aluIn2;
    sum   = {1'b0, aluIn1} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    amt   = aluIn2[SHW-1:0];
    shl_w = {1'b0, aluIn1} << amt;
    shr_w = {aluIn1, 1'b0} >> amt;
    asr_w = $unsigned($signed({aluIn1, 1'b0}) >>> amt);
    alu_r = '0;
    case (aluOp)
      OP_ADD, OP_SUB: begin
        alu_r.res = sum[WIDTH-1:0];
        alu_r.c   = sum[WIDTH];
        alu_r.v   = (aluIn1[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != aluIn1[WIDTH-1]);
      end
      OP_AND:  alu_r.res = aluIn1 & aluIn2;
      OP_OR:   alu_r.res = aluIn1 | aluIn2;
      OP_XOR:  alu_r.res = aluIn1 ^ aluIn2;
      OP_SLT:  alu_r.res = {{(WIDTH-1){1'b0}}, $signed(aluIn1) < $signed(aluIn2)};
      OP_SLTU: alu_r.res = {{(WIDTH-1){1'b0}}, aluIn1 < aluIn2};
      OP_SHL:  begin alu_r.res = shl_w[WIDTH-1:0]; alu_r.c = shl_w[WIDTH]; end
      OP_SHR:  begin alu_r.res = shr_w[WIDTH:1];   alu_r.c = shr_w[0];     end
      OP_ASR:  begin alu_r.res = asr_w[WIDTH:1];   alu_r.c = asr_w[0];     end
      OP_MUL:  alu_r.res = '0;
      default: alu_r.err = 1'b1;
    endcase
    alu_r.z = (alu_r.res == '0);
    alu_r.n = alu_r.res[WIDTH-1];
  end

  // Multiplicand shifts left and multiplier right each step, so bit[cnt] is always mplier[0].
  always_comb begin
    acc_nxt   = acc + (mplier[0] ? mcand : '0);
    mul_r     = '0;
    mul_r.res = acc_nxt[WIDTH-1:0];
    mul_r.c   = |acc_nxt[2*WIDTH-1:WIDTH];
    mul_r.z   = (acc_nxt[WIDTH-1:0] == '0);
    mul_r.n   = acc_nxt[WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (accept && aluOp == OP_MUL) begin
      cnt    <= '0;
      mcand  <= {{WIDTH{1'b0}}, aluIn1};
      mplier <= aluIn2;
      acc    <= '0;
    end else if (state == MUL) begin
      cnt    <= cnt + 1'b1;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      acc    <= acc_nxt;
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_r    <= '0;
      outValid <= 1'b0;
    end else if (accept && aluOp != OP_MUL) begin
      out_r    <= alu_r;
      outValid <= 1'b1;
    end else if (mul_done) begin
      out_r    <= mul_r;
      outValid <= 1'b1;
    end else if (outReady) begin
      outValid <= 1'b0;
    end

  assign aluOut   = out_r.res;
  assign flag_z   = out_r.z;
  assign flag_n   = out_r.n;
  assign flag_c   = out_r.c;
  assign flag_v   = out_r.v;
  assign flag_err = out_r.err;
endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed cases plus random ops against a plain-arithmetic model.
module tb_alu_pipe;
  localparam int W = 32;
  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  logic          clk = 1'b0, rst_n = 1'b1;
  logic [W-1:0]  aluIn1 = '0, aluIn2 = '0, aluOut;
  logic [3:0]    aluOp = '0;
  logic          inValid = 1'b0, inReady, outValid, outReady = 1'b0;
  logic          flag_z, flag_n, flag_c, flag_v, flag_err;
  logic [W+4:0]  obs;
  int            n_cmp = 0, n_bad = 0;

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .aluIn1(aluIn1), .aluIn2(aluIn2), .aluOp(aluOp),
    .inValid(inValid), .inReady(inReady), .aluOut(aluOut), .outValid(outValid),
    .outReady(outReady), .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c),
    .flag_v(flag_v), .flag_err(flag_err)
  );

  always #5 clk = ~clk;
  assign obs = {aluOut, flag_z, flag_n, flag_c, flag_v, flag_err};

  // Expected {result, z, n, c, v, err} from the arithmetic definition of each op.
  function automatic logic [W+4:0] model(input logic [3:0] op, input logic [W-1:0] a, b);
    logic [W-1:0] r;
    logic c, v, e;
    longint sa;
    logic [63:0] p;
    int amt;
    r = '0; c = 0; v = 0; e = 0; amt = int'(b[4:0]);
    case (op)
      4'd0: begin
        p = {32'b0, a} + {32'b0, b}; r = p[31:0]; c = p[32];
        sa = $signed(a); sa = sa + $signed(b); v = (sa > MAXS) || (sa < MINS);
      end
      4'd1: begin
        r = a - b; c = (a >= b);
        sa = $signed(a); sa = sa - $signed(b); v = (sa > MAXS) || (sa < MINS);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ($signed(a) < $signed(b)) ? 1 : 0;
      4'd6: r = (a < b) ? 1 : 0;
      4'd7: begin r = a << amt;           if (amt != 0) c = a[32-amt]; end
      4'd8: begin r = a >> amt;           if (amt != 0) c = a[amt-1];  end
      4'd9: begin r = $signed(a) >>> amt; if (amt != 0) c = a[amt-1];  end
      4'd10: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; c = (p[63:32] != 0); end
      default: e = 1;
    endcase
    return {r, (r == 0), r[W-1], c, v, e};
  endfunction

  // Issues one op with outReady high; reports result, cycles outValid stayed low, cycles inReady was low.
  task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, b,
                       output logic [W+4:0] got, output int lat, output int rdy_lo, output bit to);
    int k;
    to = 0; lat = 0; rdy_lo = 0; got = '0; k = 0;
    @(negedge clk);
    aluOp = op; aluIn1 = a; aluIn2 = b; inValid = 1; outReady = 1;
    while (!inReady && k < 200) begin @(negedge clk); k++; end
    if (!inReady) begin to = 1; inValid = 0; return; end
    @(posedge clk); #1 inValid = 0;
    @(negedge clk);
    while (!outValid && lat < 200) begin
      lat++;
      if (!inReady) rdy_lo++;
      @(negedge clk);
    end
    to = !outValid;
    got = obs;
  endtask

  task automatic test_reset;
    #2 rst_n = 0;
    #1 n_cmp++;
    if (obs !== '0 || outValid !== 0 || inReady !== 1) begin
      n_bad++; $display("FAIL reset_async: got %h v=%b r=%b expected 0 v=0 r=1", obs, outValid, inReady);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (obs !== '0 || outValid !== 0 || inReady !== 1) begin
      n_bad++; $display("FAIL reset_held: got %h v=%b r=%b expected 0 v=0 r=1", obs, outValid, inReady);
    end
    rst_n = 1;
  endtask

  task automatic test_directed;
    logic [W+4:0] got; int lat, rl; bit to;
    logic [3:0]   ops [7] = '{4'd0, 4'd1, 4'd1, 4'd9, 4'd7, 4'd10, 4'd10};
    logic [W-1:0] as  [7] = '{32'h7FFFFFFF, 32'd5, 32'd0, 32'h80000001, 32'h80000000, 32'h00010000, 32'd7};
    logic [W-1:0] bs  [7] = '{32'd1, 32'd5, 32'd1, 32'h24, 32'd1, 32'h00010000, 32'd6};
    logic [W+4:0] ex  [7] = '{{32'h80000000, 5'b01010}, {32'd0, 5'b10100}, {32'hFFFFFFFF, 5'b01000},
                              {32'hF8000000, 5'b01000}, {32'd0, 5'b10100}, {32'd0, 5'b10100},
                              {32'd42, 5'b00000}};
    for (int i = 0; i < 7; i++) begin
      do_op(ops[i], as[i], bs[i], got, lat, rl, to);
      n_cmp++;
      if (to || got !== ex[i]) begin
        n_bad++; $display("FAIL directed_%0d: got %h (to=%b) expected %h", i, got, to, ex[i]);
      end
      n_cmp++;
      if (lat != (ops[i] == 4'd10 ? W : 0) || rl != lat) begin
        n_bad++; $display("FAIL latency_%0d: got lat=%0d rdy_lo=%0d expected %0d", i, lat, rl,
                          (ops[i] == 4'd10 ? W : 0));
      end
    end
  endtask

  task automatic test_illegal;
    logic [W+4:0] got; int lat, rl; bit to;
    do_op(4'd13, $urandom, $urandom, got, lat, rl, to);
    n_cmp++;
    if (to || got !== {32'd0, 5'b10001}) begin
      n_bad++; $display("FAIL illegal_op: got %h expected %h", got, {32'd0, 5'b10001});
    end
  endtask

  task automatic test_backpressure;
    logic [W+4:0] e1, e2;
    logic [W-1:0] a1, b1, a2, b2;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
    e1 = model(4'd0, a1, b1); e2 = model(4'd0, a2, b2);
    @(negedge clk);
    outReady = 0; aluOp = 4'd0; aluIn1 = a1; aluIn2 = b1; inValid = 1;
    @(posedge clk); #1 aluIn1 = a2; aluIn2 = b2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (outValid !== 1 || obs !== e1 || inReady !== 0) begin
        n_bad++; $display("FAIL bp_hold_%0d: got %h v=%b r=%b expected %h v=1 r=0", i, obs, outValid, inReady, e1);
      end
    end
    outReady = 1;
    @(posedge clk); #1 inValid = 0;
    @(negedge clk);
    n_cmp++;
    if (outValid !== 1 || obs !== e2) begin
      n_bad++; $display("FAIL bp_second: got %h v=%b expected %h v=1", obs, outValid, e2);
    end
    @(negedge clk);
    n_cmp++;
    if (outValid !== 0) begin
      n_bad++; $display("FAIL bp_drain: got v=%b expected v=0", outValid);
    end
  endtask

  task automatic test_back_to_back;
    logic [W+4:0] q[$];
    logic [W+4:0] ex;
    logic [3:0] op;
    outReady = 1;
    @(negedge clk);
    for (int i = 0; i <= 20; i++) begin
      if (i > 0) begin
        ex = q.pop_front();
        n_cmp++;
        if (outValid !== 1 || obs !== ex) begin
          n_bad++; $display("FAIL b2b_%0d: got %h v=%b expected %h", i, obs, outValid, ex);
        end
      end
      n_cmp++;
      if (inReady !== 1) begin
        n_bad++; $display("FAIL b2b_ready_%0d: got r=%b expected 1", i, inReady);
      end
      if (i < 20) begin
        op = 4'($urandom_range(0, 14));
        if (op >= 4'd10) op = op + 4'd1;
        aluOp = op; aluIn1 = $urandom; aluIn2 = $urandom; inValid = 1;
        q.push_back(model(op, aluIn1, aluIn2));
      end else inValid = 0;
      @(negedge clk);
    end
  endtask

  task automatic test_random;
    logic [W+4:0] got, ex; int lat, rl; bit to;
    logic [3:0] op;
    logic [W-1:0] a, b;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      a = ($urandom_range(0, 3) == 0) ? 32'h80000000 >> $urandom_range(0, 31) : $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      ex = model(op, a, b);
      do_op(op, a, b, got, lat, rl, to);
      n_cmp++;
      if (to || got !== ex || lat != (op == 4'd10 ? W : 0)) begin
        n_bad++; $display("FAIL random_%0d op=%0d a=%h b=%h: got %h lat=%0d expected %h", i, op, a, b, got, lat, ex);
      end
    end
  endtask

  task automatic test_reset_mid_mul;
    logic [W+4:0] got; int lat, rl; bit to, seen;
    @(negedge clk);
    aluOp = 4'd10; aluIn1 = $urandom | 1; aluIn2 = $urandom | 1; inValid = 1; outReady = 1;
    @(posedge clk); #1 inValid = 0;
    repeat (9) @(posedge clk);
    #1 rst_n = 0;
    #1 n_cmp++;
    if (obs !== '0 || outValid !== 0 || inReady !== 1) begin
      n_bad++; $display("FAIL mul_reset: got %h v=%b r=%b expected 0 v=0 r=1", obs, outValid, inReady);
    end
    @(negedge clk) rst_n = 1;
    seen = 0;
    repeat (50) begin @(negedge clk); if (outValid) seen = 1; end
    n_cmp++;
    if (seen) begin
      n_bad++; $display("FAIL mul_reset_late: got outValid=1 expected none");
    end
    do_op(4'd4, 32'hA5A5A5A5, 32'h5A5A5A5A, got, lat, rl, to);
    n_cmp++;
    if (to || got !== {32'hFFFFFFFF, 5'b01000}) begin
      n_bad++; $display("FAIL post_reset_op: got %h expected %h", got, {32'hFFFFFFFF, 5'b01000});
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_illegal;
    test_backpressure;
    test_back_to_back;
    test_random;
    test_reset_mid_mul;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
